// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch: FSM states, field widths and
// the packed hh:mm:ss:cc time value used by the counter and lap register.
package stopwatch_pkg;

  localparam int CS_MAX  = 99;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int CS_W   = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_LAP,
    ST_LAP_PAUSE
  } state_t;

  typedef struct packed {
    logic [HOUR_W-1:0] hh;
    logic [MIN_W-1:0]  mm;
    logic [SEC_W-1:0]  ss;
    logic [CS_W-1:0]   cc;
  } time_t;

  // States in which the live count advances on a tick.
  function automatic logic is_counting(state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

  // States in which the display shows the frozen lap value.
  function automatic logic is_lapped(state_t s);
    return (s == ST_LAP) || (s == ST_LAP_PAUSE);
  endfunction

endpackage

// File: rtl/stopwatch_controller_if.sv
// Button/tick inputs and time display outputs of the stopwatch.
// master drives buttons and reads the display; slave is the controller.
interface stopwatch_controller_if;
  import stopwatch_pkg::*;

  logic              tick_100hz;
  logic              btn_start_stop;
  logic              btn_lap;
  logic              btn_clear;
  logic [HOUR_W-1:0] hours;
  logic [MIN_W-1:0]  minutes;
  logic [SEC_W-1:0]  seconds;
  logic [CS_W-1:0]   centiseconds;
  logic              running;
  logic              lap_active;

  modport master (
    output tick_100hz, btn_start_stop, btn_lap, btn_clear,
    input  hours, minutes, seconds, centiseconds, running, lap_active
  );

  modport slave (
    input  tick_100hz, btn_start_stop, btn_lap, btn_clear,
    output hours, minutes, seconds, centiseconds, running, lap_active
  );
endinterface

// File: rtl/time_counter.sv
// Cascaded hh:mm:ss:cc counter with enable and synchronous clear; hours
// wrap from HOUR_MAX back to zero.
module time_counter
  import stopwatch_pkg::*;
#(
  parameter int HOUR_MAX = 23
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  enable,
  input  logic  clear,
  output time_t count
);

  time_t count_reg;

  // Compare with '<' so a field can never step past its maximum.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      if (count_reg.cc < CS_W'(CS_MAX)) begin
        count_reg.cc <= count_reg.cc + 1'b1;
      end else begin
        count_reg.cc <= '0;
        if (count_reg.ss < SEC_W'(SEC_MAX)) begin
          count_reg.ss <= count_reg.ss + 1'b1;
        end else begin
          count_reg.ss <= '0;
          if (count_reg.mm < MIN_W'(MIN_MAX)) begin
            count_reg.mm <= count_reg.mm + 1'b1;
          end else begin
            count_reg.mm <= '0;
            if (count_reg.hh < HOUR_W'(HOUR_MAX)) begin
              count_reg.hh <= count_reg.hh + 1'b1;
            end else begin
              count_reg.hh <= '0;
            end
          end
        end
      end
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch top: run/pause/lap FSM, lap register and registered display mux
// in front of the cascaded time counter.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int HOUR_MAX = 23
) (
  input logic                    clock,
  input logic                    reset,
  stopwatch_controller_if.slave  sw
);

  state_t state_reg;
  time_t  lap_reg;
  time_t  display_reg;
  logic   running_reg;
  logic   lap_active_reg;
  time_t  live;
  logic   count_en;

  // A tick in a transition cycle follows the pre-edge state; clear beats it.
  assign count_en = sw.tick_100hz && is_counting(state_reg);

  time_counter #(
    .HOUR_MAX(HOUR_MAX)
  ) u_counter (
    .clock  (clock),
    .reset  (reset),
    .enable (count_en),
    .clear  (sw.btn_clear),
    .count  (live)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      lap_reg        <= '0;
      display_reg    <= '0;
      running_reg    <= 1'b0;
      lap_active_reg <= 1'b0;
    end else begin
      running_reg    <= is_counting(state_reg);
      lap_active_reg <= is_lapped(state_reg);
      display_reg    <= is_lapped(state_reg) ? lap_reg : live;

      // Priority clear > start_stop > lap; losers in the same cycle are dropped.
      if (sw.btn_clear) begin
        state_reg <= ST_IDLE;
        lap_reg   <= '0;
      end else if (sw.btn_start_stop) begin
        case (state_reg)
          ST_IDLE:      state_reg <= ST_RUN;
          ST_RUN:       state_reg <= ST_PAUSE;
          ST_PAUSE:     state_reg <= ST_RUN;
          ST_LAP:       state_reg <= ST_LAP_PAUSE;
          ST_LAP_PAUSE: state_reg <= ST_LAP;
          default:      state_reg <= ST_IDLE;
        endcase
      end else if (sw.btn_lap) begin
        case (state_reg)
          ST_RUN: begin
            state_reg <= ST_LAP;
            lap_reg   <= live;
          end
          ST_LAP:       state_reg <= ST_RUN;
          ST_LAP_PAUSE: state_reg <= ST_PAUSE;
          default:      state_reg <= state_reg;
        endcase
      end
    end
  end

  assign sw.hours        = display_reg.hh;
  assign sw.minutes      = display_reg.mm;
  assign sw.seconds      = display_reg.ss;
  assign sw.centiseconds = display_reg.cc;
  assign sw.running      = running_reg;
  assign sw.lap_active   = lap_active_reg;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Scoreboard bench: the driver pushes the expected display from a
// centisecond-total reference model; a monitor pops and compares.
module tb_stopwatch_controller;
  import stopwatch_pkg::*;

  localparam int HOUR_MAX = 23;
  localparam int DAY_CS   = (HOUR_MAX + 1) * 360000;

  logic clock = 1'b0;
  logic reset = 1'b1;

  stopwatch_controller_if sw();

  stopwatch_controller #(.HOUR_MAX(HOUR_MAX)) dut (
    .clock (clock),
    .reset (reset),
    .sw    (sw)
  );

  always #5 clock = ~clock;

  typedef struct {
    int    hh;
    int    mm;
    int    ss;
    int    cc;
    bit    run;
    bit    lap;
    string tag;
  } exp_t;

  exp_t  exp_q[$];
  event  chk_now;
  int    checks = 0;
  int    passed = 0;
  string phase  = "init";

  // Reference model: time as a plain centisecond total plus two mode flags.
  int live_cs = 0;
  int lap_cs  = 0;
  bit run_f   = 1'b0;
  bit lap_f   = 1'b0;

  function automatic exp_t view();
    exp_t e;
    int   t;
    t     = lap_f ? lap_cs : live_cs;
    e.hh  = t / 360000;
    e.mm  = (t / 6000) % 60;
    e.ss  = (t / 100) % 60;
    e.cc  = t % 100;
    e.run = run_f;
    e.lap = lap_f;
    e.tag = phase;
    return e;
  endfunction

  function automatic exp_t zero_view();
    exp_t e;
    e.hh = 0; e.mm = 0; e.ss = 0; e.cc = 0;
    e.run = 1'b0; e.lap = 1'b0;
    e.tag = phase;
    return e;
  endfunction

  // Called at a falling edge: drive one cycle of inputs, log expectation for
  // the coming rising edge (display lags the state by one clock), advance.
  task automatic step(input bit clr, input bit ss, input bit lp, input bit tk);
    bit inc;
    sw.btn_clear      = clr;
    sw.btn_start_stop = ss;
    sw.btn_lap        = lp;
    sw.tick_100hz     = tk;
    exp_q.push_back(view());
    inc = tk && run_f;
    if (clr) begin
      live_cs = 0; lap_cs = 0; run_f = 1'b0; lap_f = 1'b0;
    end else begin
      if (ss) begin
        run_f = !run_f;
      end else if (lp) begin
        if (run_f && !lap_f) begin
          lap_cs = live_cs;
          lap_f  = 1'b1;
        end else begin
          lap_f = 1'b0;
        end
      end
      if (inc) live_cs = (live_cs + 1) % DAY_CS;
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Asserted between edges: outputs must already read zero before any edge.
  task automatic reset_mid();
    sw.btn_clear = 1'b0; sw.btn_start_stop = 1'b0;
    sw.btn_lap = 1'b0; sw.tick_100hz = 1'b0;
    live_cs = 0; lap_cs = 0; run_f = 1'b0; lap_f = 1'b0;
    exp_q.push_back(zero_view());
    #2;
    reset = 1'b1;
    ->chk_now;
    exp_q.push_back(zero_view());
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic check_state_idle(input string tag);
    checks++;
    if (dut.state_reg == ST_IDLE) begin
      passed++;
    end else begin
      $display("FAIL %s: state=%0d, expected IDLE", tag, dut.state_reg);
    end
  endtask

  task automatic preload(input int h, input int m, input int s, input int c);
    logic [4:0] hv;
    logic [5:0] mv;
    logic [5:0] sv;
    logic [6:0] cv;
    hv = 5'(h); mv = 6'(m); sv = 6'(s); cv = 7'(c);
    dut.u_counter.count_reg = {hv, mv, sv, cv};
    live_cs = h * 360000 + m * 6000 + s * 100 + c;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock or chk_now);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (int'(sw.hours) == e.hh && int'(sw.minutes) == e.mm &&
            int'(sw.seconds) == e.ss && int'(sw.centiseconds) == e.cc &&
            sw.running == e.run && sw.lap_active == e.lap) begin
          passed++;
        end else begin
          $display("FAIL %s: got %0d:%0d:%0d.%0d run=%0b lap=%0b, expected %0d:%0d:%0d.%0d run=%0b lap=%0b",
                   e.tag, sw.hours, sw.minutes, sw.seconds, sw.centiseconds,
                   sw.running, sw.lap_active, e.hh, e.mm, e.ss, e.cc, e.run, e.lap);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passed, checks);
    $fatal(1);
  end

  initial begin : driver
    int r;
    sw.btn_clear = 1'b0; sw.btn_start_stop = 1'b0;
    sw.btn_lap = 1'b0; sw.tick_100hz = 1'b0;
    @(negedge clock);
    phase = "reset_state";
    reset_mid();
    check_state_idle("reset_state");

    phase = "start_150_ticks";
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(150);
    idle(2);

    phase = "pause_50_ticks";
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(50);
    idle(2);

    phase = "lap_hold";
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(200);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(300);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);

    phase = "hour_carry";
    preload(0, 59, 59, 99);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    phase = "day_wrap";
    preload(HOUR_MAX, 59, 59, 99);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    phase = "lap_entry_tick";
    ticks(5);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    ticks(3);
    phase = "all_pulses_in_lap";
    step(1'b1, 1'b1, 1'b1, 1'b1);
    idle(3);

    phase = "reset_mid_run";
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(725);
    idle(1);
    reset_mid();
    check_state_idle("reset_mid_run");
    step(1'b0, 1'b1, 1'b0, 1'b1);
    ticks(3);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        reset_mid();
      end else if (r < 8) begin
        preload(int'($urandom_range(0, HOUR_MAX)), 59, 59,
                int'($urandom_range(95, 99)));
      end
      step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1);
    end
    idle(3);

    @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() == 0) begin
      passed++;
    end else begin
      $display("FAIL expired_wait: %0d expectations were never checked", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    if (passed != checks) begin
      $display("FAIL summary: %0d check(s) failed", checks - passed);
      $fatal(1);
    end
    $finish;
  end

endmodule
